// File: rtl/instr_enc_pkg.sv
// Shared format codes, opcode constants and request record for the RV32I instruction encoder.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field packer: builds the 32-bit instruction word and flags out-of-range immediates.
module imm_pack
  import instr_enc_pkg::*;
(
  input  req_t        req,
  output logic [31:0] instr,
  output logic        legal
);

  always_comb begin
    instr = '0;
    legal = 1'b0;
    case (req.fmt)
      FMT_R: begin
        instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        legal = in_range(req.imm, -2048, 2047);
      end
      FMT_ISH: begin
        instr = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
        legal = in_range(req.imm, 0, 31);
      end
      FMT_S: begin
        instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        legal = in_range(req.imm, -2048, 2047);
      end
      FMT_B: begin
        instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                 req.imm[4:1], req.imm[11], req.opcode};
        legal = in_range(req.imm, -4096, 4094) && !req.imm[0];
      end
      default: begin
        instr = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder: S1 holds request fields, S2 holds the packed word for the preload path.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  req_t             req_in;
  req_t             s1_req;
  logic             s1_valid;
  logic             s2_valid;
  logic [31:0]      s2_instr;
  logic [IDX_W-1:0] idx;
  logic             err;
  logic [7:0]       err_cnt;
  logic [31:0]      packed_instr;
  logic             packed_legal;
  logic             out_fire;
  logic             s1_adv;
  logic             accept;

  always_comb begin
    req_in        = '0;
    req_in.fmt    = fmt_i;
    req_in.opcode = opcode_i;
    req_in.funct3 = funct3_i;
    req_in.funct7 = funct7_i;
    req_in.rd     = rd_i;
    req_in.rs1    = rs1_i;
    req_in.rs2    = rs2_i;
    req_in.imm    = imm_i;
  end

  imm_pack u_imm_pack (
    .req   (s1_req),
    .instr (packed_instr),
    .legal (packed_legal)
  );

  // S1 may move even when S2 is full, provided S2 drains this same cycle.
  assign out_fire   = s2_valid && out_ready_i;
  assign s1_adv     = s1_valid && (!s2_valid || out_ready_i);
  assign in_ready_o = !clear_i && (!s1_valid || s1_adv);
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s2_valid <= 1'b0;
      s2_instr <= '0;
      idx      <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else if (clear_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      idx      <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_req   <= req_in;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      // Rejected requests are consumed here: S2 stays empty and only the error state moves.
      if (s1_adv) begin
        s2_valid <= packed_legal;
        if (packed_legal) begin
          s2_instr <= packed_instr;
        end else begin
          err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
      end else if (out_fire) begin
        s2_valid <= 1'b0;
      end

      if (out_fire) idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  assign out_valid_o = s2_valid;
  assign out_instr_o = s2_instr;
  assign out_addr_o  = ADDR_BASE + (32'(idx) << 2);
  assign err_o       = err;
  assign err_cnt_o   = err_cnt;

endmodule
